// File: rtl/ctrl_pipe_hazard.sv
// Control-vector pipeline with load-use bubble insertion, freeze and deferred flush.
// Define CTRL_PIPE_PERF_EN to build the bubble/stall performance counters.
module ctrl_pipe_hazard #(
    parameter int CTRL_W     = 10,
    parameter int NUM_STAGES = 3,
    parameter int LOAD_BIT   = 8,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CTRL_W-1:0]            id_ctrl,
    input  logic                         id_valid,
    input  logic [REG_AW-1:0]            id_rs,
    input  logic [REG_AW-1:0]            id_rt,
    input  logic                         id_uses_rs,
    input  logic                         id_uses_rt,
    input  logic [REG_AW-1:0]            id_dest,
    input  logic                         ext_stall,
    input  logic                         flush,
    output logic                         stall_out,
    output logic [NUM_STAGES*CTRL_W-1:0] stage_ctrl,
    output logic [NUM_STAGES-1:0]        stage_valid,
    output logic [NUM_STAGES*REG_AW-1:0] stage_dest,
    output logic [CNT_W-1:0]             bubble_cnt
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]             stall_cnt
`endif
);

    logic [CTRL_W-1:0]     ctrl_q [NUM_STAGES];
    logic [REG_AW-1:0]     dest_q [NUM_STAGES];
    logic [NUM_STAGES-1:0] valid_q;
    logic                  flush_pending;
    logic                  haz;
    logic                  kill;

    // Only a load sitting in stage 0 with a non-$zero destination can hazard.
    always_comb begin
        haz = id_valid & valid_q[0] & ctrl_q[0][LOAD_BIT] & (dest_q[0] != '0) &
              ((id_uses_rs & (id_rs == dest_q[0])) | (id_uses_rt & (id_rt == dest_q[0])));
    end

    assign kill      = flush | flush_pending;
    assign stall_out = ext_stall | (haz & ~kill);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                ctrl_q[k] <= '0;
                dest_q[k] <= '0;
            end
            valid_q       <= '0;
            flush_pending <= 1'b0;
        end else if (ext_stall) begin
            if (flush) flush_pending <= 1'b1;
        end else begin
            for (int k = NUM_STAGES - 1; k > 0; k--) begin
                ctrl_q[k]  <= ctrl_q[k-1];
                dest_q[k]  <= dest_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
            if (kill || haz || !id_valid) begin
                ctrl_q[0]  <= '0;
                dest_q[0]  <= '0;
                valid_q[0] <= 1'b0;
            end else begin
                ctrl_q[0]  <= id_ctrl;
                dest_q[0]  <= id_dest;
                valid_q[0] <= 1'b1;
            end
            if (kill) flush_pending <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_out
        assign stage_ctrl[g*CTRL_W +: CTRL_W] = ctrl_q[g];
        assign stage_dest[g*REG_AW +: REG_AW] = dest_q[g];
    end
    assign stage_valid = valid_q;

`ifdef CTRL_PIPE_PERF_EN
    logic [CNT_W-1:0] bubble_q;
    logic [CNT_W-1:0] stall_q;
    logic             insert;

    // Bubbles from an idle decoder are not counted; only kill/hazard inserts are.
    assign insert = ~ext_stall & (kill | haz);

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_q <= '0;
            stall_q  <= '0;
        end else begin
            if (insert && (bubble_q != '1)) bubble_q <= bubble_q + CNT_W'(1);
            if (ext_stall && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign bubble_cnt = bubble_q;
    assign stall_cnt  = stall_q;
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Randomised scoreboard bench for ctrl_pipe_hazard against a history-based reference model.
module tb_ctrl_pipe_hazard;
    localparam int N    = 3;
    localparam int CW   = 10;
    localparam int AW   = 5;
    localparam int CNTW = 3;
    localparam int LB   = 8;
    localparam int RW   = 1 + N*CW + N + N*AW + 2*CNTW;

    typedef struct packed {
        logic          v;
        logic [CW-1:0] c;
        logic [AW-1:0] d;
    } ent_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [CW-1:0]   id_ctrl = '0;
    logic            id_valid = 1'b0;
    logic [AW-1:0]   id_rs = '0, id_rt = '0, id_dest = '0;
    logic            id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic            ext_stall = 1'b0, flush = 1'b0;
    logic            stall_out;
    logic [N*CW-1:0] stage_ctrl;
    logic [N-1:0]    stage_valid;
    logic [N*AW-1:0] stage_dest;
    logic [CNTW-1:0] bubble_cnt;
`ifdef CTRL_PIPE_PERF_EN
    logic [CNTW-1:0] stall_cnt;
`endif

    ctrl_pipe_hazard #(.CTRL_W(CW), .NUM_STAGES(N), .LOAD_BIT(LB), .REG_AW(AW), .CNT_W(CNTW)) dut (
        .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .ext_stall(ext_stall), .flush(flush), .stall_out(stall_out),
        .stage_ctrl(stage_ctrl), .stage_valid(stage_valid), .stage_dest(stage_dest),
        .bubble_cnt(bubble_cnt)
`ifdef CTRL_PIPE_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: history of what entered stage 0; stage k shows the k-th most recent entry.
    ent_t            hist[$];
    logic            fp_m;
    int              bub_m, stl_m;
    logic [RW-1:0]   exp_q[$];
    int              n_vec = 0, n_bad = 0;

    function automatic ent_t stage_m(int k);
        if (hist.size() > k) return hist[hist.size()-1-k];
        return '0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, es, fl, iv, input logic [CW-1:0] c,
                        input logic [AW-1:0] rs, rt, input logic urs, urt,
                        input logic [AW-1:0] d, output logic st);
        ent_t          s0, e;
        logic          haz, kill;
        logic [N*CW-1:0] rc;
        logic [N*AW-1:0] rd;
        logic [N-1:0]    rv;
        logic [CNTW-1:0] eb, es_cnt;
        @(negedge clk);
        reset = rst; ext_stall = es; flush = fl; id_valid = iv; id_ctrl = c;
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt; id_dest = d;
        #1;
        s0   = stage_m(0);
        haz  = iv && s0.v && s0.c[LB] && (s0.d != 0) && ((urs && rs == s0.d) || (urt && rt == s0.d));
        kill = fl || fp_m;
        st   = es || (haz && !kill);
        for (int k = 0; k < N; k++) begin
            e = stage_m(k);
            rc[k*CW +: CW] = e.c;
            rd[k*AW +: AW] = e.d;
            rv[k] = e.v;
        end
`ifdef CTRL_PIPE_PERF_EN
        eb = CNTW'(bub_m);
`else
        eb = '0;
`endif
        es_cnt = CNTW'(stl_m);
        exp_q.push_back({st, rc, rv, rd, eb, es_cnt});
        if (rst) begin
            hist.delete(); fp_m = 1'b0; bub_m = 0; stl_m = 0;
        end else if (es) begin
            if (fl) fp_m = 1'b1;
            if (stl_m < (1 << CNTW) - 1) stl_m++;
        end else begin
            if (kill || haz) begin
                e = '0;
                if (bub_m < (1 << CNTW) - 1) bub_m++;
                fp_m = 1'b0;
            end else begin
                e.v = iv; e.c = iv ? c : '0; e.d = iv ? d : '0;
            end
            hist.push_back(e);
            if (hist.size() > N) void'(hist.pop_front());
        end
    endtask

    // Monitor: compares DUT outputs to the oldest pending expectation each cycle.
    initial begin
        logic [RW-1:0] r;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                check("stall_out", 64'(stall_out), 64'(r[RW-1]));
                check("stage_ctrl", 64'(stage_ctrl), 64'(r[RW-2 -: N*CW]));
                check("stage_valid", 64'(stage_valid), 64'(r[RW-2-N*CW -: N]));
                check("stage_dest", 64'(stage_dest), 64'(r[2*CNTW + N*AW - 1 -: N*AW]));
                check("bubble_cnt", 64'(bubble_cnt), 64'(r[2*CNTW-1 -: CNTW]));
`ifdef CTRL_PIPE_PERF_EN
                check("stall_cnt", 64'(stall_cnt), 64'(r[CNTW-1:0]));
`endif
            end
        end
    end

    initial begin
        logic          st;
        logic          iv, urs, urt;
        logic [CW-1:0] c;
        logic [AW-1:0] rs, rt, d;
        fp_m = 1'b0; bub_m = 0; stl_m = 0;
        // Reset, then pass-through of three instructions.
        step(1, 0, 0, 0, '0, 0, 0, 0, 0, 0, st);
        step(1, 0, 0, 0, '0, 0, 0, 0, 0, 0, st);
        step(0, 0, 0, 1, 10'b1000000011, 0, 0, 0, 0, 5, st);
        step(0, 0, 0, 1, 10'b0000100001, 0, 0, 0, 0, 6, st);
        step(0, 0, 0, 1, 10'b1110000000, 0, 0, 0, 0, 7, st);
        repeat (3) step(0, 0, 0, 0, '0, 0, 0, 0, 0, 0, st);
        // Load-use on r8, then the same pattern with $zero destination.
        step(0, 0, 0, 1, 10'b0110000010, 0, 0, 0, 0, 8, st);
        step(0, 0, 0, 1, 10'b0000000001, 8, 0, 1, 0, 9, st);
        step(0, 0, 0, 1, 10'b0000000001, 8, 0, 1, 0, 9, st);
        step(0, 0, 0, 1, 10'b0110000010, 0, 0, 0, 0, 0, st);
        step(0, 0, 0, 1, 10'b0000000001, 0, 0, 1, 0, 9, st);
        // Freeze for three cycles with a flush in the middle one.
        step(0, 1, 0, 1, 10'b0000000011, 0, 0, 0, 0, 4, st);
        step(0, 1, 1, 1, 10'b0000000011, 0, 0, 0, 0, 4, st);
        step(0, 1, 0, 1, 10'b0000000011, 0, 0, 0, 0, 4, st);
        step(0, 0, 0, 1, 10'b0000000011, 0, 0, 0, 0, 4, st);
        step(0, 0, 0, 1, 10'b0000000011, 0, 0, 0, 0, 4, st);
        // Flush coincident with a hazard.
        step(0, 0, 0, 1, 10'b0110000000, 0, 0, 0, 0, 9, st);
        step(0, 0, 1, 1, 10'b0000000101, 0, 9, 0, 1, 2, st);
        step(0, 0, 0, 1, 10'b0000000101, 0, 9, 0, 1, 2, st);
        // Saturation: chained dependent loads, then four freeze cycles.
        step(1, 0, 0, 0, '0, 0, 0, 0, 0, 0, st);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 10'b0100000000, 3, 0, 1, 0, 3, st);
        repeat (4) step(0, 1, 0, 0, '0, 0, 0, 0, 0, 0, st);
        step(0, 0, 0, 0, '0, 0, 0, 0, 0, 0, st);
        // Random traffic; ID holds its instruction while stalled.
        st = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!st) begin
                iv  = ($urandom_range(0, 9) != 0);
                c   = CW'($urandom_range(0, 1023));
                rs  = AW'($urandom_range(0, 3));
                rt  = AW'($urandom_range(0, 3));
                urs = 1'($urandom_range(0, 1));
                urt = 1'($urandom_range(0, 1));
                d   = AW'($urandom_range(0, 3));
            end
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0), iv, c, rs, rt, urs, urt, d, st);
        end
        @(negedge clk);
        #3;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
